// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the LSU data-memory request path. Accepts one word-aligned
//   request at a time, waits LATENCY cycles, commits stores (per-byte lanes)
//   or reads the addressed word, and presents the result on a valid/ready
//   response channel. Sub-word extraction and sign extension stay in the LSU.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  request present
//   req_ready  responder can accept a request (IDLE only, never during rst)
//   req_we     1 = store, 0 = load
//   req_addr   byte address; word index = req_addr[31:2]
//   req_be     byte-lane enables, bit i = lane i
//   req_wdata  lane-aligned store data
//   rsp_valid  response present
//   rsp_ready  LSU accepts the response
//   rsp_rdata  full read word (0 for stores and faults)
//   rsp_err    range or byte-enable fault
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  // Counter only has to hold LATENCY-2.
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic          lat_we;
  logic [31:0]   lat_addr;
  logic [3:0]    lat_be;
  logic [31:0]   lat_wdata;

  logic [31:0]   mem [DEPTH];

  logic          accept;
  logic          commit;
  logic          c_we;
  logic [31:0]   c_addr;
  logic [3:0]    c_be;
  logic [31:0]   c_wdata;
  logic [31:0]   c_idx;
  logic          be_ok;
  logic          c_err;

  assign req_ready = (state == S_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // With single-cycle latency the commit happens on the acceptance edge
  // itself, so the request is taken straight from the ports; otherwise the
  // copy latched at acceptance is used.
  assign c_we    = (LATENCY == 1) ? req_we    : lat_we;
  assign c_addr  = (LATENCY == 1) ? req_addr  : lat_addr;
  assign c_be    = (LATENCY == 1) ? req_be    : lat_be;
  assign c_wdata = (LATENCY == 1) ? req_wdata : lat_wdata;
  assign commit  = (LATENCY == 1) ? accept
                                  : ((state == S_WAIT) && (cnt == '0));

  // Full 30-bit word index takes part in the range check, so high address
  // bits never alias onto a legal word.
  assign c_idx = c_addr >> 2;

  // NOTE: every variable assigned in always_comb gets a default first so no
  // latch is inferred on an unlisted path.
  always_comb begin
    be_ok = 1'b0;
    case (c_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: be_ok = 1'b1;
      default:                   be_ok = 1'b0;
    endcase
  end

  assign c_err = (c_idx >= 32'(DEPTH)) || !be_ok;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (LATENCY != 1) begin
              state <= S_WAIT;
              cnt   <= CW'(LATENCY - 2);
            end
          end
        end
        S_WAIT: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      // Entering RESP: resolve the response exactly once.
      if (commit) begin
        state     <= S_RESP;
        rsp_valid <= 1'b1;
        rsp_err   <= c_err;
        rsp_rdata <= (c_we || c_err) ? 32'h0 : mem[c_idx[AW-1:0]];
      end
    end
  end

  // Request capture carries no reset: these are only consumed after an
  // acceptance has loaded them.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_we    <= req_we;
      lat_addr  <= req_addr;
      lat_be    <= req_be;
      lat_wdata <= req_wdata;
    end
  end

  // NOTE: the memory array is deliberately not reset, so it maps onto RAM
  // and keeps its contents across rst.
  always_ff @(posedge clk) begin
    if (commit && !rst && c_we && !c_err) begin
      for (int i = 0; i < 4; i++) begin
        if (c_be[i]) mem[c_idx[AW-1:0]][8*i +: 8] <= c_wdata[8*i +: 8];
      end
    end
  end

endmodule
